osel_serial_tx: RTL and testbench
=================================

Name: osel_serial_tx

Overview:
- Transmit side of the select-vector path: takes a parallel select word (same layout as the osel register, bit 0 = lane 0) over a valid/ready handshake.
- Shifts the word out LSB-first on a single serial line, with a frame qualifier and per-bit strobe.
- Lets a narrow downstream link reconstruct the osel vector bit by bit.
- Sits between the instruction-decode/latch stage and the serial select link.

Parameters:
- WIDTH, 8: bits per select word; legal range 2..32.
- CLKDIV, 4: clk cycles per serial bit; legal range 1..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- in_valid  input  1  parallel word available
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  select word to transmit, bit 0 sent first
- ser_out  output  1  serial data
- ser_frame  output  1  high for every cycle a data bit is being driven
- ser_strobe  output  1  one-cycle pulse in the first cycle of each bit period
- done  output  1  one-cycle pulse after the last bit of a word

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (resetn).
- All outputs are registered.
- Reset (resetn low, any time, including mid-frame):
  - State returns to IDLE and the shift register, bit counter and divider clear immediately.
  - ser_out=0, ser_frame=0, ser_strobe=0, done=0, in_ready=0 while resetn is low.
  - in_ready=1 on the first rising edge after resetn deasserts.
  - A partially sent word is discarded; nothing is resumed.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - in_ready=1; ser_frame=0; ser_out=0.
  - Handshake fires at edge N when in_valid && in_ready.
  - On that edge: capture in_data into the shift register, clear bit_cnt and div_cnt, go to SHIFT.
- SHIFT:
  - in_ready=0, ser_frame=1, ser_out=shreg[0].
  - div_cnt counts 0..CLKDIV-1; ser_strobe=1 when div_cnt==0.
  - At div_cnt==CLKDIV-1: shift the register right by one, bit_cnt+1, div_cnt back to 0.
  - When bit_cnt==WIDTH-1 and div_cnt==CLKDIV-1, go to DONE.
- Bit k occupies cycles N+1+k*CLKDIV through N+(k+1)*CLKDIV.
- Frame length is exactly WIDTH*CLKDIV cycles.
- DONE:
  - Lasts one cycle, at N+WIDTH*CLKDIV+1: done=1, ser_frame=0, ser_out=0, in_ready=0.
  - Then go to IDLE.
- Throughput: next accept at earliest on edge N+WIDTH*CLKDIV+2, giving WIDTH*CLKDIV+2 cycles per word.
- in_valid/in_data while not in IDLE: ignored, no effect on the word in flight. The sender holds in_valid and in_data until accepted.
- CLKDIV=1: ser_strobe is high every SHIFT cycle and the shift happens every cycle.
- Counter widths: bit_cnt is ceil(log2(WIDTH)) bits; div_cnt is 8 bits. No wrap beyond the terminal counts.

Test Plan:
- Reset: hold resetn low for 3 cycles with in_valid=1 -> all outputs 0, in_ready=0. First edge after release -> in_ready=1, ser_frame=0.
- Single word, WIDTH=8, CLKDIV=4, in_data=8'h08 accepted at edge N:
  - ser_frame=1 for cycles N+1..N+32.
  - ser_out=1 only in N+13..N+16.
  - ser_strobe at N+1, N+5, ..., N+29.
  - done=1 at N+33; in_ready=1 at N+34.
- Back-to-back, in_valid held high with 8'hA5 then 8'h3C:
  - Second accept occurs exactly 34 cycles after the first.
  - Bits sampled on each strobe give 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- Busy stimulus: change in_data to 8'hFF and toggle in_valid during SHIFT of 8'h01 -> serial pattern stays 1,0,0,0,0,0,0,0; no extra done.
- Reset mid-frame: assert resetn low at bit 4 of 8'hFF, asynchronously between edges:
  - ser_out and ser_frame drop to 0 without waiting for a clock edge.
  - After release, no residual bits and no done.
  - A new word 8'h81 then transmits correctly.
- CLKDIV=1, WIDTH=4, in_data=4'b1011 -> ser_out 1,1,0,1 on consecutive cycles N+1..N+4, ser_strobe high all four cycles, done at N+5.

Source files
------------

// File: rtl/osel_serial_tx.sv
// Serialises a parallel select word LSB-first with frame/strobe qualifiers; WIDTH*CLKDIV+2 cycles per word.
// in_ready is high only in IDLE; a held in_valid/in_data is taken on the first IDLE edge, otherwise ignored.
module osel_serial_tx #(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             ser_strobe,
    output logic             done
);

    localparam int             BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
    localparam logic [7:0]     DIV_LAST = 8'(CLKDIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]       div_cnt, div_cnt_nxt;
    logic             out_nxt, frame_nxt, strobe_nxt, done_nxt, ready_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            in_ready   <= 1'b0;
            ser_out    <= 1'b0;
            ser_frame  <= 1'b0;
            ser_strobe <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            div_cnt    <= div_cnt_nxt;
            in_ready   <= ready_nxt;
            ser_out    <= out_nxt;
            ser_frame  <= frame_nxt;
            ser_strobe <= strobe_nxt;
            done       <= done_nxt;
        end
    end

    // in_ready is the registered copy, so the first IDLE cycle after reset cannot accept.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        div_cnt_nxt = div_cnt;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shreg_nxt   = in_data;
                    bit_cnt_nxt = '0;
                    div_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    shreg_nxt   = shreg >> 1;
                    div_cnt_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = DONE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 8'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next-state values so every port comes straight from a flop.
    always_comb begin
        ready_nxt  = (state_nxt == IDLE);
        frame_nxt  = (state_nxt == SHIFT);
        out_nxt    = frame_nxt & shreg_nxt[0];
        strobe_nxt = frame_nxt && (div_cnt_nxt == 8'd0);
        done_nxt   = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_osel_serial_tx.sv
// Directed bench for osel_serial_tx: an 8x4 instance and a 4x1 instance sharing clock and reset.
module tb_osel_serial_tx;

    logic       clk;
    logic       resetn;
    logic       in_valid0, in_ready0, ser_out0, ser_frame0, ser_strobe0, done0;
    logic [7:0] in_data0;
    logic       in_valid1, in_ready1, ser_out1, ser_frame1, ser_strobe1, done1;
    logic [3:0] in_data1;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    osel_serial_tx #(.WIDTH(8), .CLKDIV(4)) dut0 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_data   (in_data0),
        .ser_out   (ser_out0),
        .ser_frame (ser_frame0),
        .ser_strobe(ser_strobe0),
        .done      (done0)
    );

    osel_serial_tx #(.WIDTH(4), .CLKDIV(1)) dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .ser_out   (ser_out1),
        .ser_frame (ser_frame1),
        .ser_strobe(ser_strobe1),
        .done      (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int which, output logic o, output logic f, output logic s,
                          output logic d, output logic r);
        if (which == 0) begin
            o = ser_out0; f = ser_frame0; s = ser_strobe0; d = done0; r = in_ready0;
        end else begin
            o = ser_out1; f = ser_frame1; s = ser_strobe1; d = done1; r = in_ready1;
        end
    endtask

    task automatic drive(input int which, input logic v, input logic [7:0] data);
        if (which == 0) begin
            in_valid0 = v;
            in_data0  = data;
        end else begin
            in_valid1 = v;
            in_data1  = data[3:0];
        end
    endtask

    // Sends one word and checks every cycle from N+1 to N+w*c+2 against the timing formulas.
    task automatic send_word(input int which, input logic [7:0] data, input int w, input int c,
                             input bit keep, input bit busy, input int exp_wait);
        int         waits;
        int         nb;
        int         len;
        logic       o, f, s, d, r;
        logic [7:0] got;
        logic [7:0] mask;
        waits = 0;
        nb    = 0;
        got   = '0;
        len   = w * c + 2;
        mask  = 8'((1 << w) - 1);
        sample(which, o, f, s, d, r);
        while (!r && waits < 200) begin
            tick();
            waits++;
            sample(which, o, f, s, d, r);
        end
        chk($sformatf("ready_before_%0h", data), 32'(r), 32'd1);
        if (exp_wait >= 0) chk($sformatf("accept_gap_%0h", data), 32'(waits), 32'(exp_wait));
        drive(which, 1'b1, data);
        tick();
        if (!keep) drive(which, 1'b0, data);
        for (int cyc = 1; cyc <= len; cyc++) begin
            sample(which, o, f, s, d, r);
            chk($sformatf("frame_%0h_c%0d", data, cyc), 32'(f), 32'(cyc <= w * c));
            chk($sformatf("out_%0h_c%0d", data, cyc), 32'(o),
                (cyc <= w * c) ? 32'(data[(cyc - 1) / c]) : 32'd0);
            chk($sformatf("strobe_%0h_c%0d", data, cyc), 32'(s),
                32'((cyc <= w * c) && (((cyc - 1) % c) == 0)));
            chk($sformatf("done_%0h_c%0d", data, cyc), 32'(d), 32'(cyc == w * c + 1));
            chk($sformatf("ready_%0h_c%0d", data, cyc), 32'(r), 32'(cyc == len));
            if (s && nb < 8) begin
                got[nb] = o;
                nb++;
            end
            if (cyc < len) begin
                if (busy) drive(which, 1'(cyc % 2), 8'hFF);
                tick();
            end
        end
        if (busy || !keep) drive(which, 1'b0, data);
        chk($sformatf("strobe_count_%0h", data), 32'(nb), 32'(w));
        chk($sformatf("strobe_word_%0h", data), 32'(got & mask), 32'(data & mask));
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid0 = 1'b1;
        in_data0  = 8'h08;
        in_valid1 = 1'b0;
        in_data1  = 4'h0;

        repeat (3) tick();
        chk("rst_out0",    32'(ser_out0),    32'd0);
        chk("rst_frame0",  32'(ser_frame0),  32'd0);
        chk("rst_strobe0", 32'(ser_strobe0), 32'd0);
        chk("rst_done0",   32'(done0),       32'd0);
        chk("rst_ready0",  32'(in_ready0),   32'd0);
        chk("rst_frame1",  32'(ser_frame1),  32'd0);
        chk("rst_ready1",  32'(in_ready1),   32'd0);

        resetn = 1'b1;
        tick();
        chk("post_rst_ready0", 32'(in_ready0),  32'd1);
        chk("post_rst_frame0", 32'(ser_frame0), 32'd0);
        chk("post_rst_ready1", 32'(in_ready1),  32'd1);

        send_word(0, 8'h08, 8, 4, 1'b0, 1'b0, 0);

        // Back-to-back with in_valid held: zero extra wait means accepts are 34 edges apart.
        send_word(0, 8'hA5, 8, 4, 1'b1, 1'b0, 0);
        send_word(0, 8'h3C, 8, 4, 1'b0, 1'b0, 0);

        send_word(0, 8'h01, 8, 4, 1'b0, 1'b1, 0);
        repeat (3) begin
            tick();
            chk("busy_idle_done",  32'(done0),      32'd0);
            chk("busy_idle_frame", 32'(ser_frame0), 32'd0);
        end

        // Reset asserted between edges during bit 4 of 8'hFF.
        drive(0, 1'b1, 8'hFF);
        tick();
        drive(0, 1'b0, 8'hFF);
        repeat (16) tick();
        chk("mid_bit4_frame", 32'(ser_frame0), 32'd1);
        chk("mid_bit4_out",   32'(ser_out0),   32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_out",    32'(ser_out0),    32'd0);
        chk("async_rst_frame",  32'(ser_frame0),  32'd0);
        chk("async_rst_strobe", 32'(ser_strobe0), 32'd0);
        chk("async_rst_ready",  32'(in_ready0),   32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("after_rst_frame_%0d", i), 32'(ser_frame0), 32'd0);
            chk($sformatf("after_rst_done_%0d", i),  32'(done0),      32'd0);
        end
        send_word(0, 8'h81, 8, 4, 1'b0, 1'b0, -1);

        send_word(1, 8'h0B, 4, 1, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
